// File: rtl/regfile_wb_queue_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue_if
// Bundle of every non-clock/reset signal of regfile_wb_queue.
//
// Handshake rule for both producer channels (alu_*, mem_*): a result moves
// from producer to queue on a rising clk edge where valid && ready are both
// high; dest/data are sampled on that edge. Ready never depends on the
// same channel's valid.
//
// Modports:
//   master : producer / decode / register-file side (drives valids, payloads,
//            bypass read indices; observes readies, write port, status)
//   slave  : the writeback queue itself
// ---------------------------------------------------------------------------
interface regfile_wb_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_data;

    logic              rg_wrt_enable;
    logic [ADDR_W-1:0] rg_wrt_dest;
    logic [DATA_W-1:0] rg_wrt_data;

    logic [NREG-1:0]   busy;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] byp_addr1;
    logic [ADDR_W-1:0] byp_addr2;
    logic              byp_hit1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] byp_data2;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        output byp_addr1, byp_addr2,
        input  alu_ready, mem_ready,
        input  rg_wrt_enable, rg_wrt_dest, rg_wrt_data,
        input  busy, count,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        input  byp_addr1, byp_addr2,
        output alu_ready, mem_ready,
        output rg_wrt_enable, rg_wrt_dest, rg_wrt_data,
        output busy, count,
        output byp_hit1, byp_hit2, byp_data1, byp_data2
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
// Writeback-side initiator for the register file. Accepts ALU and load
// results, keeps them in a small in-order circular queue and drives the
// register file's single write port at one write per cycle.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   wb   : regfile_wb_queue_if.slave
//          alu_*/mem_*   producer handshakes (valid/ready, dest, data)
//          rg_wrt_*      registered write port (stable across falling edge)
//          busy, count   hazard status from registered state
//          byp_*         newest-pending-value bypass for two read ports
//
// Optional feature: define WB_BYPASS_EN to build the bypass search; without
// it byp_hit*/byp_data* are tied to zero.
//
// The load channel wins the last free slot: alu_ready needs two free slots
// whenever mem_valid is high. A same-edge drain is not credited to free
// space, so readiness depends only on the registered count and mem_valid.
// ---------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_queue_if.slave  wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_dest_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              mem_ready, alu_ready;
    logic              mem_acc, alu_acc, pop;
    logic [PTR_W-1:0]  alu_slot;

    assign mem_ready = (count_q < CNT_W'(DEPTH));
    assign alu_ready = (count_q <= CNT_W'(DEPTH - 2)) || (mem_ready && !wb.mem_valid);

    assign mem_acc = wb.mem_valid && mem_ready;
    assign alu_acc = wb.alu_valid && alu_ready;
    assign pop     = (count_q != '0);

    // Load entry is older than a same-edge ALU entry, so it takes the tail.
    assign alu_slot = mem_acc ? tail_q + PTR_W'(1) : tail_q;

    assign tail_d  = tail_q + PTR_W'(mem_acc) + PTR_W'(alu_acc);
    assign head_d  = head_q + PTR_W'(pop);
    assign count_d = count_q + CNT_W'(mem_acc) + CNT_W'(alu_acc) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (mem_acc) begin
                dest_q[tail_q] <= wb.mem_dest;
                data_q[tail_q] <= wb.mem_data;
            end
            if (alu_acc) begin
                dest_q[alu_slot] <= wb.alu_dest;
                data_q[alu_slot] <= wb.alu_data;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Write port holds its last dest/data when idle.
            wr_en_q <= pop;
            if (pop) begin
                wr_dest_q <= dest_q[head_q];
                wr_data_q <= data_q[head_q];
            end
        end
    end

    // Pending-write flags: every live queue entry plus the in-flight write.
    logic [NREG-1:0] busy_c;
    always_comb begin
        busy_c = '0;
        if (wr_en_q) busy_c[wr_dest_q] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) busy_c[dest_q[head_q + PTR_W'(i)]] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to newest (in-flight, then head..tail) so the last match
    // seen is the newest pending value.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        wb.byp_hit1  = 1'b0;
        wb.byp_data1 = '0;
        wb.byp_hit2  = 1'b0;
        wb.byp_data2 = '0;
        if (wr_en_q && wr_dest_q == wb.byp_addr1) begin
            wb.byp_hit1  = 1'b1;
            wb.byp_data1 = wr_data_q;
        end
        if (wr_en_q && wr_dest_q == wb.byp_addr2) begin
            wb.byp_hit2  = 1'b1;
            wb.byp_data2 = wr_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (dest_q[idx] == wb.byp_addr1) begin
                    wb.byp_hit1  = 1'b1;
                    wb.byp_data1 = data_q[idx];
                end
                if (dest_q[idx] == wb.byp_addr2) begin
                    wb.byp_hit2  = 1'b1;
                    wb.byp_data2 = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_byp;
    assign unused_byp   = ^{wb.byp_addr1, wb.byp_addr2};
    assign wb.byp_hit1  = 1'b0;
    assign wb.byp_hit2  = 1'b0;
    assign wb.byp_data1 = '0;
    assign wb.byp_data2 = '0;
`endif

    assign wb.mem_ready     = mem_ready;
    assign wb.alu_ready     = alu_ready;
    assign wb.rg_wrt_enable = wr_en_q;
    assign wb.rg_wrt_dest   = wr_dest_q;
    assign wb.rg_wrt_data   = wr_data_q;
    assign wb.busy          = busy_c;
    assign wb.count         = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue
// Directed bench for regfile_wb_queue (DATA_W=8, ADDR_W=2, DEPTH=4).
// Inputs are driven 1 time unit after a rising edge; outputs are checked
// after that edge once combinational paths have settled.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_queue_if wb ();
    regfile_wb_queue dut (.clk(clk), .rst(rst), .wb(wb));

    int checks = 0;
    int passed = 0;
    int wr_seen = 0;
    bit mon_on = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    // Count register-file writes at the capturing (falling) edge.
    always @(negedge clk) if (mon_on && wb.rg_wrt_enable === 1'b1) wr_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
    endtask

    task automatic drive_alu(input logic [1:0] d, input logic [7:0] v);
        wb.alu_valid = 1'b1;
        wb.alu_dest  = d;
        wb.alu_data  = v;
    endtask

    task automatic drive_mem(input logic [1:0] d, input logic [7:0] v);
        wb.mem_valid = 1'b1;
        wb.mem_dest  = d;
        wb.mem_data  = v;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        wb.alu_valid = 1'b0; wb.alu_dest = '0; wb.alu_data = '0;
        wb.mem_valid = 1'b0; wb.mem_dest = '0; wb.mem_data = '0;
        wb.byp_addr1 = '0;   wb.byp_addr2 = '0;
        #1 rst = 1'b0;
        #11;
        chk("rst_wr_en",   32'(wb.rg_wrt_enable), 32'd0);
        chk("rst_wr_dest", 32'(wb.rg_wrt_dest),   32'd0);
        chk("rst_wr_data", 32'(wb.rg_wrt_data),   32'd0);
        chk("rst_busy",    32'(wb.busy),          32'd0);
        chk("rst_count",   32'(wb.count),         32'd0);
        chk("rst_mem_rdy", 32'(wb.mem_ready),     32'd1);
        chk("rst_alu_rdy", 32'(wb.alu_ready),     32'd1);
        @(negedge clk) rst = 1'b1;
        tick(); tick();
        chk("post_rst_wr_en", 32'(wb.rg_wrt_enable), 32'd0);

        // ---------------- single write ----------------
        drive_alu(2'd2, 8'h5A);
        wb.byp_addr1 = 2'd2;
        settle();
        chk("single_alu_rdy", 32'(wb.alu_ready), 32'd1);
        tick();                                   // edge t: accepted
        idle(); settle();
        chk("single_t_count", 32'(wb.count),         32'd1);
        chk("single_t_wr_en", 32'(wb.rg_wrt_enable), 32'd0);
        chk("single_t_busy",  32'(wb.busy),          32'h4);
        chk("single_t_hit1",  32'(wb.byp_hit1),      32'(BYP));
        chk("single_t_data1", 32'(wb.byp_data1),     BYP ? 32'h5A : 32'h0);
        tick();                                   // edge t+1: write issued
        chk("single_t1_wr_en", 32'(wb.rg_wrt_enable), 32'd1);
        chk("single_t1_dest",  32'(wb.rg_wrt_dest),   32'd2);
        chk("single_t1_data",  32'(wb.rg_wrt_data),   32'h5A);
        chk("single_t1_count", 32'(wb.count),         32'd0);
        chk("single_t1_busy",  32'(wb.busy),          32'h4);
        chk("single_t1_data1", 32'(wb.byp_data1),     BYP ? 32'h5A : 32'h0);
        tick();                                   // edge t+2: idle again
        chk("single_t2_wr_en", 32'(wb.rg_wrt_enable), 32'd0);
        chk("single_t2_busy",  32'(wb.busy),          32'h0);
        chk("single_t2_dest",  32'(wb.rg_wrt_dest),   32'd2);
        chk("single_t2_data",  32'(wb.rg_wrt_data),   32'h5A);
        chk("single_t2_hit1",  32'(wb.byp_hit1),      32'd0);

        // ---------------- dual accept / ordering ----------------
        drive_mem(2'd1, 8'h11);
        drive_alu(2'd1, 8'h22);
        wb.byp_addr1 = 2'd1;
        settle();
        chk("dual_mem_rdy", 32'(wb.mem_ready), 32'd1);
        chk("dual_alu_rdy", 32'(wb.alu_ready), 32'd1);
        tick();
        idle(); settle();
        chk("dual_count",   32'(wb.count),     32'd2);
        chk("dual_busy",    32'(wb.busy),      32'h2);
        chk("dual_q_data1", 32'(wb.byp_data1), BYP ? 32'h22 : 32'h0);
        tick();
        chk("dual_w1_en",    32'(wb.rg_wrt_enable), 32'd1);
        chk("dual_w1_dest",  32'(wb.rg_wrt_dest),   32'd1);
        chk("dual_w1_data",  32'(wb.rg_wrt_data),   32'h11);
        chk("dual_w1_count", 32'(wb.count),         32'd1);
        chk("dual_w1_data1", 32'(wb.byp_data1),     BYP ? 32'h22 : 32'h0);
        tick();
        chk("dual_w2_en",    32'(wb.rg_wrt_enable), 32'd1);
        chk("dual_w2_data",  32'(wb.rg_wrt_data),   32'h22);
        chk("dual_w2_count", 32'(wb.count),         32'd0);
        chk("dual_w2_data1", 32'(wb.byp_data1),     BYP ? 32'h22 : 32'h0);
        tick();
        chk("dual_done_en",   32'(wb.rg_wrt_enable), 32'd0);
        chk("dual_done_hit1", 32'(wb.byp_hit1),      32'd0);

        // ---------------- fill to count=3, last-slot priority ----------------
        drive_mem(2'd0, 8'hA0);
        drive_alu(2'd1, 8'hA1);
        tick();
        drive_mem(2'd2, 8'hB2);
        drive_alu(2'd3, 8'hB3);
        settle();
        chk("fill_count2",  32'(wb.count),     32'd2);
        chk("fill_alu_rdy", 32'(wb.alu_ready), 32'd1);
        tick();                                   // drain keeps level at 3
        wb.mem_valid = 1'b0;
        drive_alu(2'd1, 8'hC1);
        settle();
        chk("full_count3",     32'(wb.count),       32'd3);
        chk("full_wr_data",    32'(wb.rg_wrt_data), 32'hA0);
        chk("full_alu_rdy_nm", 32'(wb.alu_ready),   32'd1);
        drive_mem(2'd0, 8'hC0);
        wb.byp_addr1 = 2'd3;
        wb.byp_addr2 = 2'd0;
        settle();
        chk("full_mem_rdy", 32'(wb.mem_ready), 32'd1);
        chk("full_alu_rdy", 32'(wb.alu_ready), 32'd0);
        chk("full_busy",    32'(wb.busy),      32'hF);
        chk("full_hit1",    32'(wb.byp_hit1),  32'(BYP));
        chk("full_data1",   32'(wb.byp_data1), BYP ? 32'hB3 : 32'h0);
        chk("full_data2",   32'(wb.byp_data2), BYP ? 32'hA0 : 32'h0);
        tick();                                   // only the load is taken
        idle(); settle();
        chk("prio_count",   32'(wb.count),       32'd3);
        chk("prio_wr_dest", 32'(wb.rg_wrt_dest), 32'd1);
        chk("prio_wr_data", 32'(wb.rg_wrt_data), 32'hA1);
        chk("prio_busy",    32'(wb.busy),        32'hF);
        chk("prio_data2",   32'(wb.byp_data2),   BYP ? 32'hC0 : 32'h0);
        tick();
        chk("drain_b2",   32'(wb.rg_wrt_data), 32'hB2);
        chk("drain_cnt2", 32'(wb.count),       32'd2);
        tick();
        chk("drain_b3",   32'(wb.rg_wrt_data), 32'hB3);
        tick();
        chk("drain_c0",   32'(wb.rg_wrt_data), 32'hC0);
        chk("drain_cnt0", 32'(wb.count),       32'd0);
        tick();
        chk("drain_idle_en",   32'(wb.rg_wrt_enable), 32'd0);
        chk("drain_idle_busy", 32'(wb.busy),          32'h0);

        // ---------------- wrap-around stream ----------------
        mon_on  = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i % 2 == 0) drive_alu(2'(i % 4), 8'(i));
            else            drive_mem(2'(i % 4), 8'(i));
            exp_q.push_back(8'(i));
            settle();
            if (i % 2 == 0) chk("wrap_alu_rdy", 32'(wb.alu_ready), 32'd1);
            else            chk("wrap_mem_rdy", 32'(wb.mem_ready), 32'd1);
            tick();
            chk("wrap_count", 32'(wb.count), 32'd1);
            if (i > 0) begin
                e = exp_q.pop_front();
                chk("wrap_wr_en",   32'(wb.rg_wrt_enable), 32'd1);
                chk("wrap_wr_data", 32'(wb.rg_wrt_data),   32'(e));
                chk("wrap_wr_dest", 32'(wb.rg_wrt_dest),   32'(e % 4));
            end
        end
        idle();
        tick();
        e = exp_q.pop_front();
        chk("wrap_last_data", 32'(wb.rg_wrt_data), 32'(e));
        chk("wrap_last_cnt",  32'(wb.count),       32'd0);
        tick();
        chk("wrap_end_en", 32'(wb.rg_wrt_enable), 32'd0);
        mon_on = 1'b0;
        chk("wrap_writes", 32'(wr_seen), 32'd10);

        // ---------------- reset mid-stream ----------------
        drive_mem(2'd0, 8'hD0);
        drive_alu(2'd1, 8'hD1);
        tick();
        drive_mem(2'd2, 8'hD2);
        drive_alu(2'd3, 8'hD3);
        tick();
        idle();
        wb.byp_addr1 = 2'd3;
        settle();
        chk("mid_pre_count", 32'(wb.count), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wb.rg_wrt_enable), 32'd0);
        chk("mid_rst_dest",  32'(wb.rg_wrt_dest),   32'd0);
        chk("mid_rst_data",  32'(wb.rg_wrt_data),   32'd0);
        chk("mid_rst_busy",  32'(wb.busy),          32'd0);
        chk("mid_rst_count", 32'(wb.count),         32'd0);
        chk("mid_rst_hit1",  32'(wb.byp_hit1),      32'd0);
        chk("mid_rst_data1", 32'(wb.byp_data1),     32'd0);
        tick();
        @(negedge clk) rst = 1'b1;
        tick(); tick();
        chk("mid_post_wr_en", 32'(wb.rg_wrt_enable), 32'd0);
        chk("mid_post_count", 32'(wb.count),         32'd0);
        chk("mid_post_busy",  32'(wb.busy),          32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
